// File: rtl/route_cmd_arbiter.sv
// Round-robin command arbiter and connection-image validator for the 8-pole / 28-pair interlock stage.
// Optional LOCKOUT_EN adds a lockout input that rejects connect commands while asserted.
module route_cmd_arbiter #(
    parameter int unsigned HOLD_CYCLES = 600000,
    parameter int unsigned CNT_W       = 20
) (
    input  logic        pclk_50M,
    input  logic        rst,
    input  logic        req_a,
    input  logic [7:0]  cmd_a,
    output logic        ack_a,
    output logic        err_a,
    input  logic        req_b,
    input  logic [7:0]  cmd_b,
    output logic        ack_b,
    output logic        err_b,
`ifdef LOCKOUT_EN
    input  logic        lockout,
`endif
    output logic [1:8]  outP,
    output logic [1:28] out,
    output logic        busy
);

    typedef enum logic [1:0] {S_IDLE, S_DECODE, S_APPLY, S_HOLD} state_e;

    localparam logic [1:0] OP_RSVD = 2'b00;
    localparam logic [1:0] OP_CONN = 2'b01;
    localparam logic [1:0] OP_DISC = 2'b10;
    localparam logic [1:0] OP_CLR  = 2'b11;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    state_e           state_q;
    logic [7:0]       cmd_q;
    logic             gnt_b_q;
    logic             ptr_b_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:8]       outp_q;
    logic [1:28]      out_q;
    logic             ack_a_q, err_a_q, ack_b_q, err_b_q, busy_q;

    logic       elig_a, elig_b, pick_b;
    logic [1:0] op;
    logic [2:0] pa, pb, lo, hi;
    logic [3:0] p_idx, q_idx;
    logic [4:0] pair_idx;
    logic       lock_conn;
    logic       reject;

    // Triangular number hi*(hi-1)/2: pairs whose upper pole is below pole hi+1.
    function automatic logic [4:0] tri_num(input logic [2:0] n);
        case (n)
            3'd0, 3'd1: tri_num = 5'd0;
            3'd2:       tri_num = 5'd1;
            3'd3:       tri_num = 5'd3;
            3'd4:       tri_num = 5'd6;
            3'd5:       tri_num = 5'd10;
            3'd6:       tri_num = 5'd15;
            default:    tri_num = 5'd21;
        endcase
    endfunction

`ifdef LOCKOUT_EN
    assign lock_conn = lockout;
`else
    assign lock_conn = 1'b0;
`endif

    // A requester whose ack is high this cycle still shows its stale req.
    assign elig_a = req_a & ~ack_a_q;
    assign elig_b = req_b & ~ack_b_q;
    assign pick_b = (elig_a & elig_b) ? ptr_b_q : elig_b;

    // NOTE: every variable gets a default at the top of always_comb so no latch is inferred.
    always_comb begin
        op       = cmd_q[7:6];
        pa       = cmd_q[5:3];
        pb       = cmd_q[2:0];
        lo       = (pa < pb) ? pa : pb;
        hi       = (pa < pb) ? pb : pa;
        p_idx    = {1'b0, lo} + 4'd1;
        q_idx    = {1'b0, hi} + 4'd1;
        pair_idx = tri_num(hi) + {2'b00, lo} + 5'd1;
        reject   = 1'b0;
        case (op)
            OP_RSVD: reject = 1'b1;
            OP_CONN: reject = (pa == pb) | outp_q[p_idx] | outp_q[q_idx] | lock_conn;
            OP_DISC: reject = (pa == pb) | ~out_q[pair_idx];
            default: reject = 1'b0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge pclk_50M or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cmd_q   <= '0;
            gnt_b_q <= 1'b0;
            ptr_b_q <= 1'b0;
            cnt_q   <= '0;
            outp_q  <= '0;
            out_q   <= '0;
            ack_a_q <= 1'b0;
            err_a_q <= 1'b0;
            ack_b_q <= 1'b0;
            err_b_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            ack_a_q <= 1'b0;
            err_a_q <= 1'b0;
            ack_b_q <= 1'b0;
            err_b_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (elig_a | elig_b) begin
                        cmd_q   <= pick_b ? cmd_b : cmd_a;
                        gnt_b_q <= pick_b;
                        ptr_b_q <= ~pick_b;
                        busy_q  <= 1'b1;
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (reject) begin
                        ack_a_q <= ~gnt_b_q;
                        err_a_q <= ~gnt_b_q;
                        ack_b_q <= gnt_b_q;
                        err_b_q <= gnt_b_q;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        state_q <= S_APPLY;
                    end
                end
                S_APPLY: begin
                    case (op)
                        OP_CONN: begin
                            outp_q[p_idx]   <= 1'b1;
                            outp_q[q_idx]   <= 1'b1;
                            out_q[pair_idx] <= 1'b1;
                        end
                        OP_DISC: begin
                            outp_q[p_idx]   <= 1'b0;
                            outp_q[q_idx]   <= 1'b0;
                            out_q[pair_idx] <= 1'b0;
                        end
                        OP_CLR: begin
                            outp_q <= '0;
                            out_q  <= '0;
                        end
                        default: ;
                    endcase
                    ack_a_q <= ~gnt_b_q;
                    ack_b_q <= gnt_b_q;
                    cnt_q   <= '0;
                    state_q <= S_HOLD;
                end
                default: begin
                    // Break-before-make settle window downstream.
                    if (cnt_q == HOLD_LAST) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    assign ack_a = ack_a_q;
    assign err_a = err_a_q;
    assign ack_b = ack_b_q;
    assign err_b = err_b_q;
    assign outP  = outp_q;
    assign out   = out_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_route_cmd_arbiter.sv
// Scoreboard bench for route_cmd_arbiter: random and directed commands checked against a pole/pair set model.
module tb_route_cmd_arbiter;

    localparam int HOLD = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_a = 1'b0, req_b = 1'b0;
    logic [7:0]  cmd_a = '0, cmd_b = '0;
    logic        ack_a, err_a, ack_b, err_b, busy;
    logic        lockout = 1'b0;
    logic [1:8]  outP;
    logic [1:28] out;

    route_cmd_arbiter #(.HOLD_CYCLES(HOLD), .CNT_W(20)) dut (
        .pclk_50M(clk), .rst(rst),
        .req_a(req_a), .cmd_a(cmd_a), .ack_a(ack_a), .err_a(err_a),
        .req_b(req_b), .cmd_b(cmd_b), .ack_b(ack_b), .err_b(err_b),
`ifdef LOCKOUT_EN
        .lockout(lockout),
`endif
        .outP(outP), .out(out), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          side_b;
        bit          err;
        logic [1:8]  outp;
        logic [1:28] outv;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0, failures = 0;
    int          cyc = 0, ack_total = 0, lat_first = 0, busy_run = 0;
    int          ack_cycles[$];
    int          busy_runs[$];

    // Reference model: set of energised poles and pairs, plus the round-robin pointer.
    logic [1:8]  m_outP = '0;
    logic [1:28] m_out = '0;
    bit          m_ptr_b = 1'b0;
    bit          m_lockout = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic bit model_cmd(input logic [7:0] c);
        int op, a, b, p, q, idx;
        op  = int'(c[7:6]);
        a   = int'(c[5:3]) + 1;
        b   = int'(c[2:0]) + 1;
        p   = (a < b) ? a : b;
        q   = (a < b) ? b : a;
        idx = (q - 1) * (q - 2) / 2 + p;
        case (op)
            1: begin
                if (a == b || m_outP[p] || m_outP[q] || m_lockout) return 1'b1;
                m_outP[p] = 1'b1; m_outP[q] = 1'b1; m_out[idx] = 1'b1;
                return 1'b0;
            end
            2: begin
                if (a == b || !m_out[idx]) return 1'b1;
                m_outP[p] = 1'b0; m_outP[q] = 1'b0; m_out[idx] = 1'b0;
                return 1'b0;
            end
            3: begin
                m_outP = '0; m_out = '0;
                return 1'b0;
            end
            default: return 1'b1;
        endcase
    endfunction

    function automatic void push(input bit side_b, input logic [7:0] c);
        bit e;
        e = model_cmd(c);
        m_ptr_b = !side_b;
        sb.push_back('{side_b, e, m_outP, m_out});
    endfunction

    function automatic logic [7:0] gen_cmd();
        int r, k;
        logic [2:0] a, b, t;
        int fr[$];
        int pr[$];
        r = $urandom_range(0, 9);
        a = 3'($urandom_range(0, 7));
        b = 3'($urandom_range(0, 7));
        if (r == 0) return {2'b00, a, b};
        if (r == 1) return {2'b11, a, b};
        if (r <= 5) begin
            for (int i = 1; i <= 8; i++) if (!m_outP[i]) fr.push_back(i - 1);
            if (fr.size() >= 2 && $urandom_range(0, 3) != 0) begin
                k = $urandom_range(0, fr.size() - 1);
                a = 3'(fr[k]);
                fr.delete(k);
                b = 3'(fr[$urandom_range(0, fr.size() - 1)]);
            end
            return {2'b01, a, b};
        end
        for (int p = 1; p <= 8; p++)
            for (int q = p + 1; q <= 8; q++)
                if (m_out[(q - 1) * (q - 2) / 2 + p]) pr.push_back((p - 1) * 8 + (q - 1));
        if (pr.size() > 0 && $urandom_range(0, 3) != 0) begin
            k = $urandom_range(0, pr.size() - 1);
            a = 3'(pr[k] / 8);
            b = 3'(pr[k] % 8);
            if ($urandom_range(0, 1) == 1) begin t = a; a = b; b = t; end
        end
        return {2'b10, a, b};
    endfunction

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst) busy_run = 0;
        else if (busy) busy_run++;
        else if (busy_run != 0) begin
            busy_runs.push_back(busy_run);
            busy_run = 0;
        end
    end

    // Monitor: pops one expectation per ack pulse.
    always @(negedge clk) begin
        if (!rst) begin
            if ((err_a && !ack_a) || (err_b && !ack_b)) check("err_without_ack", {err_a, err_b}, 0);
            if (ack_a || ack_b) begin
                ack_total++;
                ack_cycles.push_back(cyc);
                if (sb.size() == 0) check("unexpected_ack", {ack_a, ack_b}, 0);
                else begin
                    mon_e = sb.pop_front();
                    check("ack_side", {ack_a, ack_b}, mon_e.side_b ? 2'b01 : 2'b10);
                    check("ack_err", mon_e.side_b ? err_b : err_a, mon_e.err);
                    check("image", {outP, out}, {mon_e.outp, mon_e.outv});
                end
            end
        end
    end

    task automatic issue(input bit use_a, input bit use_b, input logic [7:0] ca, input logic [7:0] cb);
        bit first_b, pend_a, pend_b;
        int n;
        first_b = (use_a && use_b) ? m_ptr_b : use_b;
        push(first_b, first_b ? cb : ca);
        if (use_a && use_b) push(!first_b, first_b ? ca : cb);
        @(negedge clk);
        req_a = use_a; cmd_a = ca; req_b = use_b; cmd_b = cb;
        pend_a = use_a; pend_b = use_b; n = 0; lat_first = 0;
        while ((pend_a || pend_b) && n < 2 * (HOLD + 6) + 10) begin
            @(negedge clk);
            n++;
            if (ack_a && pend_a) begin req_a = 1'b0; pend_a = 1'b0; if (lat_first == 0) lat_first = n; end
            if (ack_b && pend_b) begin req_b = 1'b0; pend_b = 1'b0; if (lat_first == 0) lat_first = n; end
        end
        check("ack_timeout", {pend_a, pend_b}, 0);
        req_a = 1'b0; req_b = 1'b0;
        n = 0;
        while (busy && n < HOLD + 10) begin @(negedge clk); n++; end
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, nc, ack_before;

        repeat (3) @(negedge clk);
        check("rst_outP", outP, 0);
        check("rst_out", out, 0);
        check("rst_busy", busy, 0);
        check("rst_ack_err", {ack_a, err_a, ack_b, err_b}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        busy_runs.delete();
        issue(1, 0, 8'b01_000_001, 8'h00);
        check("conn12_latency", lat_first, 3);
        check("conn12_outP", outP, 8'b1100_0000);
        check("conn12_out1", out[1], 1);
        check("conn12_busy_len", busy_runs.size() > 0 ? busy_runs[0] : 0, HOLD + 2);

        issue(1, 0, 8'b11_000_000, 8'h00);
        issue(1, 0, 8'b01_010_111, 8'h00);
        busy_runs.delete();
        issue(1, 0, 8'b01_111_100, 8'h00);
        check("conflict_latency", lat_first, 2);
        check("conflict_busy_len", busy_runs.size() > 0 ? busy_runs[0] : 0, 1);
        check("conflict_out24", out[24], 1);
        check("conflict_outP", outP, 8'b0010_0001);

        issue(0, 1, 8'h00, 8'b10_001_010);
        issue(1, 0, 8'b00_000_001, 8'h00);
        issue(0, 1, 8'h00, 8'b01_011_011);
        issue(0, 1, 8'h00, 8'b10_111_010);

        // Reset in the middle of HOLD with B waiting.
        issue(1, 0, 8'b11_000_000, 8'h00);
        push(0, 8'b01_000_001);
        @(negedge clk);
        req_a = 1'b1; cmd_a = 8'b01_000_001;
        n = 0;
        while (!ack_a && n < 50) begin @(negedge clk); n++; end
        req_a = 1'b0;
        check("rstmid_ack_seen", ack_a, 1);
        req_b = 1'b1; cmd_b = 8'b01_010_011;
        repeat (2) @(negedge clk);
        check("rstmid_pre_outP", outP, 8'b1100_0000);
        #2 rst = 1'b1;
        #1;
        check("rstmid_outP", outP, 0);
        check("rstmid_out", out, 0);
        check("rstmid_busy", busy, 0);
        check("rstmid_ack", {ack_a, ack_b}, 0);
        req_b = 1'b0;
        m_outP = '0; m_out = '0; m_ptr_b = 1'b0;
        ack_before = ack_total;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3 * HOLD) @(negedge clk);
        check("no_ack_after_rst", ack_total - ack_before, 0);

        issue(1, 1, 8'b01_000_001, 8'b01_010_011);
        nc = ack_cycles.size();
        check("sim1_hold_gap", nc >= 2 ? ack_cycles[nc - 1] - ack_cycles[nc - 2] : 0, HOLD + 3);
        issue(1, 0, 8'b10_000_001, 8'h00);
        issue(1, 1, 8'b01_000_001, 8'b10_010_011);
        nc = ack_cycles.size();
        check("sim2_hold_gap", nc >= 2 ? ack_cycles[nc - 1] - ack_cycles[nc - 2] : 0, HOLD + 3);

        for (int i = 0; i < 80; i++) begin
            int mode;
            logic [7:0] c1, c2;
            mode = $urandom_range(0, 2);
            c1 = gen_cmd();
            c2 = gen_cmd();
            issue(mode != 1, mode != 0, c1, c2);
        end

`ifdef LOCKOUT_EN
        issue(1, 0, 8'b11_000_000, 8'h00);
        lockout = 1'b1; m_lockout = 1'b1;
        issue(1, 0, 8'b01_000_001, 8'h00);
        issue(0, 1, 8'h00, 8'b11_000_000);
        check("lockout_outP", outP, 0);
        lockout = 1'b0; m_lockout = 1'b0;
`endif

        repeat (5) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
